down_count_ctrl: RTL and testbench

- Synchronous controller that sequences a programmable down counter: configuration handshake, start, pause, stop, terminal-count detection and optional auto-reload.
- Sits between a register or host interface and the counter datapath. Replaces free-running ripple counting with a single-clock, FSM-controlled count.
- The count register, terminal-count pulse and status are all generated inside this block.

---
 rtl/down_count_pkg.sv | 19 +
 rtl/down_count_ctrl_if.sv | 18 +
 rtl/down_count_presc.sv | 38 +++
 rtl/down_count_ctrl.sv | 132 +++++++++++++
 tb/tb_down_count_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/down_count_pkg.sv
// Shared types and constants for the down-count controller.
//------------------------------------------------------------------------------
// down_count_pkg : state encoding and default widths
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none
package down_count_pkg;
  localparam int ST_W      = 3;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } st_e;
endpackage
`default_nettype wire

// File: rtl/down_count_ctrl_if.sv
// Configuration handshake bundle between host and controller.
//------------------------------------------------------------------------------
// down_count_ctrl_if : cfg valid/ready handshake with load value and mode
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none
interface down_count_ctrl_if #(
  parameter int CNT_W = down_count_pkg::CNT_W_DEF
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_load;
  logic             cfg_reload;

  modport master (output cfg_valid, output cfg_load, output cfg_reload, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_load, input cfg_reload, output cfg_ready);
endinterface
`default_nettype wire

// File: rtl/down_count_presc.sv
// Tick prescaler: passes every DIV-th enabled tick.
//------------------------------------------------------------------------------
// down_count_presc : 8-bit tick divider with synchronous clear
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none
module down_count_presc #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic tick_in,
  output logic tick_out
);
  localparam logic [7:0] LAST = 8'(DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  // tick_out must not depend on clr so the parent's clear path stays acyclic
  assign tick_out = en && tick_in && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && tick_in) begin
      cnt_d = tick_out ? 8'd0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule
`default_nettype wire

// File: rtl/down_count_ctrl.sv
// FSM-sequenced programmable down counter with terminal-count and auto-reload.
// Optional tick prescaler enabled by macro DOWN_COUNT_CTRL_PRESCALE_EN.
//------------------------------------------------------------------------------
// down_count_ctrl : top-level controller, FSM and count register
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none
module down_count_ctrl
  import down_count_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int PRESC_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  down_count_ctrl_if.slave  cfg,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  output logic [CNT_W-1:0]  count,
  output logic              tc_pulse,
  output logic              done,
  output logic              busy,
  output logic [ST_W-1:0]   state
);
  st_e              state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic             auto_q, auto_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             cfg_acc;
  logic             qtick;

  assign cfg.cfg_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign cfg_acc       = cfg.cfg_valid && cfg.cfg_ready;

`ifdef DOWN_COUNT_CTRL_PRESCALE_EN
  logic presc_clr;
  logic presc_en;

  assign presc_clr = stop || ((state_d == ST_RUN) && (state_q != ST_RUN));
  assign presc_en  = (state_q == ST_RUN) && !pause && !stop;

  down_count_presc #(.DIV(PRESC_DIV)) u_presc (
    .clk      (clk),
    .rst      (rst),
    .clr      (presc_clr),
    .en       (presc_en),
    .tick_in  (tick),
    .tick_out (qtick)
  );
`else
  logic presc_div_unused;
  assign presc_div_unused = ^8'(PRESC_DIV);
  assign qtick            = tick;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    auto_d   = auto_q;
    tc_d     = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (cfg_acc) begin
      reload_d = cfg.cfg_load;
      count_d  = cfg.cfg_load;
      auto_d   = cfg.cfg_reload;
      state_d  = ST_ARMED;
    end else begin
      case (state_q)
        ST_ARMED: if (start) state_d = ST_RUN;
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (qtick) begin
            if (count_q != '0) begin
              count_d = count_q - CNT_W'(1);
            end else begin
              tc_d = 1'b1;
              if (auto_q) count_d = reload_q;
              else        state_d = ST_DONE;
            end
          end
        end
        ST_PAUSE: if (!pause) state_d = ST_RUN;
        ST_DONE: begin
          if (start) begin
            count_d = reload_q;
            state_d = ST_RUN;
          end
        end
        default: ;
      endcase
    end
    // status flags track the next state so they change together with state
    done_d = (state_d == ST_DONE);
    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      auto_q   <= 1'b0;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      auto_q   <= auto_d;
      tc_q     <= tc_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign count    = count_q;
  assign tc_pulse = tc_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign state    = state_q;
endmodule
`default_nettype wire

// File: tb/tb_down_count_ctrl.sv
// Self-checking bench for down_count_ctrl: vector table, corner sequences, random vs model.
`default_nettype none
module tb_down_count_ctrl;
  localparam int CNT_W = 4;
`ifdef DOWN_COUNT_CTRL_PRESCALE_EN
  localparam int QDIV = 4;
`else
  localparam int QDIV = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0, start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic [CNT_W-1:0] count;
  logic tc_pulse, done, busy;
  logic [2:0] state;

  down_count_ctrl_if #(.CNT_W(CNT_W)) cfg_if ();

  down_count_ctrl #(.CNT_W(CNT_W), .PRESC_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .cfg      (cfg_if),
    .start    (start),
    .pause    (pause),
    .stop     (stop),
    .count    (count),
    .tc_pulse (tc_pulse),
    .done     (done),
    .busy     (busy),
    .state    (state)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic tk; logic cv; logic [CNT_W-1:0] ld; logic rl; logic go; logic ps; logic sp;
  } in_t;

  typedef struct {
    in_t i; int cnt; int st; int tc; int dn;
  } vec_t;

  // Reference model: state numbers as given in the state output encoding
  int m_st, m_cnt, m_rel, m_auto, m_tc, m_pre;

  function automatic in_t mk(logic tk, logic cv, int ld, logic rl, logic go, logic ps, logic sp);
    in_t v;
    v.tk = tk; v.cv = cv; v.ld = CNT_W'(ld); v.rl = rl; v.go = go; v.ps = ps; v.sp = sp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_rel = 0; m_auto = 0; m_tc = 0; m_pre = 0;
  endtask

  task automatic model_step(input in_t v);
    bit q;
    m_tc = 0;
    if (v.sp) begin
      m_st = 0; m_cnt = 0; m_pre = 0;
    end else if (v.cv && (m_st == 0 || m_st == 4)) begin
      m_rel = int'(v.ld); m_cnt = m_rel; m_auto = int'(v.rl); m_st = 1;
    end else if (m_st == 1) begin
      if (v.go) begin m_st = 2; m_pre = 0; end
    end else if (m_st == 2) begin
      if (v.ps) m_st = 3;
      else if (v.tk) begin
        m_pre = m_pre + 1;
        q = (m_pre == QDIV);
        if (q) m_pre = 0;
        if (q) begin
          if (m_cnt > 0) m_cnt = m_cnt - 1;
          else begin
            m_tc = 1;
            if (m_auto != 0) m_cnt = m_rel;
            else m_st = 4;
          end
        end
      end
    end else if (m_st == 3) begin
      if (!v.ps) begin m_st = 2; m_pre = 0; end
    end else if (m_st == 4) begin
      if (v.go) begin m_cnt = m_rel; m_st = 2; m_pre = 0; end
    end
  endtask

  function automatic logic [31:0] pack_dut();
    return {20'd0, count, tc_pulse, done, busy, state, cfg_if.cfg_ready};
  endfunction

  function automatic logic [31:0] pack_model();
    return {20'd0, CNT_W'(m_cnt), m_tc[0], m_st == 4, (m_st == 2 || m_st == 3),
            3'(m_st), (m_st == 0 || m_st == 4)};
  endfunction

  task automatic cyc(input in_t v);
    @(negedge clk);
    tick = v.tk; cfg_if.cfg_valid = v.cv; cfg_if.cfg_load = v.ld; cfg_if.cfg_reload = v.rl;
    start = v.go; pause = v.ps; stop = v.sp;
    model_step(v);
    @(posedge clk);
    #1;
    chk("cycle{cnt,tc,done,busy,st,rdy}", pack_dut(), pack_model());
  endtask

  in_t idle_v, tick_v;
  vec_t tbl[$];
  int n_tc;
  bit saw_done;

  initial begin
    idle_v = mk(0, 0, 0, 0, 0, 0, 0);
    tick_v = mk(1, 0, 0, 0, 0, 0, 0);
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_load = '0; cfg_if.cfg_reload = 1'b0;
    model_reset();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_flags{tc,done,busy}", {29'd0, tc_pulse, done, busy}, 0);
    chk("rst_cfg_ready", 32'(cfg_if.cfg_ready), 1);
    @(negedge clk);
    rst = 1'b1;

`ifndef DOWN_COUNT_CTRL_PRESCALE_EN
    // one-shot load 3, then DONE with simultaneous cfg+start, then load-0 terminal
    tbl.push_back('{mk(0,1,3,0,0,0,0), 3, 1, 0, 0});
    tbl.push_back('{mk(1,0,0,0,1,0,0), 3, 2, 0, 0});
    tbl.push_back('{tick_v,             2, 2, 0, 0});
    tbl.push_back('{tick_v,             1, 2, 0, 0});
    tbl.push_back('{idle_v,             1, 2, 0, 0});
    tbl.push_back('{tick_v,             0, 2, 0, 0});
    tbl.push_back('{tick_v,             0, 4, 1, 1});
    tbl.push_back('{tick_v,             0, 4, 0, 1});
    tbl.push_back('{mk(1,1,0,0,1,0,0), 0, 1, 0, 0});
    tbl.push_back('{mk(0,0,0,0,1,0,0), 0, 2, 0, 0});
    tbl.push_back('{tick_v,             0, 4, 1, 1});
    tbl.push_back('{mk(0,0,0,0,1,0,0), 0, 2, 0, 0});
    tbl.push_back('{tick_v,             0, 4, 1, 1});
    foreach (tbl[k]) begin
      cyc(tbl[k].i);
      chk($sformatf("tbl%0d_count", k), 32'(count), 32'(tbl[k].cnt));
      chk($sformatf("tbl%0d_state", k), 32'(state), 32'(tbl[k].st));
      chk($sformatf("tbl%0d_tc", k), 32'(tc_pulse), 32'(tbl[k].tc));
      chk($sformatf("tbl%0d_done", k), 32'(done), 32'(tbl[k].dn));
    end
    cyc(mk(0, 0, 0, 0, 0, 0, 1));
`endif

    // reset mid-run
    cyc(mk(0, 1, 5, 0, 0, 0, 0));
    cyc(mk(0, 0, 0, 0, 1, 0, 0));
    cyc(tick_v);
    cyc(tick_v);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_state", 32'(state), 0);
    chk("async_rst_ready", 32'(cfg_if.cfg_ready), 1);
    chk("async_rst_tc", 32'(tc_pulse), 0);
    model_reset();
    @(posedge clk); #1;
    chk("rst_hold_tc", 32'(tc_pulse), 0);
    @(negedge clk); rst = 1'b1;

    // auto-reload, period 3 qualifying ticks, 10 periods
    cyc(mk(0, 1, 2, 1, 0, 0, 0));
    cyc(mk(1, 0, 0, 0, 1, 0, 0));
    n_tc = 0; saw_done = 0;
    for (int k = 0; k < 30 * QDIV; k++) begin
      cyc(tick_v);
      if (tc_pulse) n_tc++;
      if (done) saw_done = 1;
    end
    chk("auto_tc_pulses", 32'(n_tc), 10);
    chk("auto_done_low", 32'(saw_done), 0);
    cyc(mk(0, 0, 0, 0, 0, 0, 1));

    // pause and stop
    cyc(mk(0, 1, 9, 0, 0, 0, 0));
    cyc(mk(0, 0, 0, 0, 1, 0, 0));
    for (int k = 0; k < 3 * QDIV; k++) cyc(tick_v);
    chk("run3_count", 32'(count), 6);
    for (int k = 0; k < 5; k++) cyc(mk(1, 0, 0, 0, 0, 1, 0));
    chk("pause_count", 32'(count), 6);
    chk("pause_state", 32'(state), 3);
    cyc(tick_v);
    chk("resume_count", 32'(count), 6);
    chk("resume_state", 32'(state), 2);
    for (int k = 0; k < QDIV; k++) cyc(tick_v);
    chk("resume_dec", 32'(count), 5);
    chk("run_cfg_ready", 32'(cfg_if.cfg_ready), 0);
    cyc(mk(0, 1, 7, 1, 0, 0, 0));
    chk("run_cfg_ignored", 32'(count), 5);
    cyc(mk(1, 0, 0, 0, 0, 0, 1));
    chk("stop_state", 32'(state), 0);
    chk("stop_count", 32'(count), 0);
    chk("stop_tc", 32'(tc_pulse), 0);

`ifdef DOWN_COUNT_CTRL_PRESCALE_EN
    // prescaler: load 1, decrement on 4th tick, terminal on 8th
    cyc(mk(0, 1, 1, 0, 0, 0, 0));
    cyc(mk(1, 0, 0, 0, 1, 0, 0));
    for (int k = 1; k <= 8; k++) begin
      cyc(tick_v);
      chk($sformatf("presc_t%0d_count", k), 32'(count), (k < 4) ? 1 : 0);
      chk($sformatf("presc_t%0d_tc", k), 32'(tc_pulse), (k == 8) ? 1 : 0);
    end
    chk("presc_done_state", 32'(state), 4);
`endif

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      cyc(mk($urandom_range(99) < 70, $urandom_range(99) < 20, int'($urandom_range(15)),
             1'($urandom), $urandom_range(99) < 30, $urandom_range(99) < 12,
             $urandom_range(99) < 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
`default_nettype wire
